// File: rtl/seg7_scan_if.sv
// Bus between the display scan logic and the 7-segment scan decoder.
// The err_cnt signal exists only when SEG7_ERR_CNT_EN is defined.
interface seg7_scan_if #(
    parameter int DIGITS = 4
);
    logic [DIGITS-1:0]   an_in;
    logic [6:0]          seg_in;
    logic [4*DIGITS-1:0] digits_out;
    logic [DIGITS-1:0]   invalid_out;
    logic                frame_valid;
`ifdef SEG7_ERR_CNT_EN
    logic [7:0]          err_cnt;

    modport master (output an_in, seg_in, input digits_out, invalid_out, frame_valid, err_cnt);
    modport slave  (input an_in, seg_in, output digits_out, invalid_out, frame_valid, err_cnt);
`else
    modport master (output an_in, seg_in, input digits_out, invalid_out, frame_valid);
    modport slave  (input an_in, seg_in, output digits_out, invalid_out, frame_valid);
`endif
endinterface

// File: rtl/seg7_scan_decoder.sv
// Decodes a multiplexed common-anode 7-segment bus back to per-digit BCD and flags frames.
// Optional saturating error counter enabled with SEG7_ERR_CNT_EN.
module seg7_scan_decoder #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);
    localparam int SW = DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef struct packed {
        logic [3:0] val;
        logic       bad;
    } dec_t;

    function automatic dec_t decode(input logic [6:0] seg);
        dec_t d;
        d.bad = 1'b0;
        case (seg)
            7'b1000000: d.val = 4'd0;
            7'b1111001: d.val = 4'd1;
            7'b0100100: d.val = 4'd2;
            7'b0110000: d.val = 4'd3;
            7'b0011001: d.val = 4'd4;
            7'b0010010: d.val = 4'd5;
            7'b0000010: d.val = 4'd6;
            7'b1111000: d.val = 4'd7;
            7'b0000000: d.val = 4'd8;
            7'b0010000: d.val = 4'd9;
            7'b1111111: d.val = 4'hF;
            default: begin
                d.val = 4'hE;
                d.bad = 1'b1;
            end
        endcase
        return d;
    endfunction

    logic [SW-1:0]       samp_q;
    logic [CW-1:0]       stab_q;
    logic [DIGITS-1:0]   seen_q;
    logic [4*DIGITS-1:0] digits_q;
    logic [DIGITS-1:0]   invalid_q;
    logic                fv_q;

    logic [SW-1:0]       sample;
    logic                same;
    logic                capture;
    logic [DIGITS-1:0]   an_s;
    int                  low_cnt;
    logic [IW-1:0]       idx;
    logic                one_low;
    logic                multi_low;
    dec_t                dec;
    logic [DIGITS-1:0]   seen_next;

    assign sample = {bus.an_in, bus.seg_in};
    assign same   = (sample == samp_q);
    // The sample taken at this edge is compared against the one held from the last edge,
    // so a pattern first sampled at edge N is captured at edge N+STABLE_CYC.
    assign capture = same && (stab_q == CW'(STABLE_CYC - 1));
    assign an_s    = samp_q[SW-1:7];
    assign dec     = decode(samp_q[6:0]);

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        low_cnt = 0;
        idx     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_s[i]) begin
                low_cnt = low_cnt + 1;
                idx     = IW'(i);
            end
        end
        one_low   = (low_cnt == 1);
        multi_low = (low_cnt > 1);
        seen_next = seen_q | (DIGITS'(1) << idx);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers
    // see pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q    <= '1;
            stab_q    <= '0;
            seen_q    <= '0;
            digits_q  <= '1;
            invalid_q <= '0;
            fv_q      <= 1'b0;
        end else begin
            samp_q <= sample;
            fv_q   <= 1'b0;
            if (!same)
                stab_q <= '0;
            else if (stab_q != CW'(STABLE_CYC))
                stab_q <= stab_q + CW'(1);

            // Blanking (all anodes high) and multi-anode errors leave digits and mask alone.
            if (capture && one_low) begin
                digits_q[4*idx +: 4] <= dec.val;
                invalid_q[idx]       <= dec.bad;
                if (&seen_next) begin
                    fv_q   <= 1'b1;
                    seen_q <= '0;
                end else begin
                    seen_q <= seen_next;
                end
            end
        end
    end

    assign bus.digits_out  = digits_q;
    assign bus.invalid_out = invalid_q;
    assign bus.frame_valid = fv_q;

`ifdef SEG7_ERR_CNT_EN
    logic [7:0] err_q;

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= '0;
        else if (capture && (multi_low || (one_low && dec.bad)) && (err_q != 8'hFF))
            err_q <= err_q + 8'd1;
    end

    assign bus.err_cnt = err_q;
`endif
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder (DIGITS=4, STABLE_CYC=4); directed scan vectors.
// err_cnt expectations are checked only when SEG7_ERR_CNT_EN is defined.
module tb_seg7_scan_decoder;
    localparam logic [3:0] IDLE_AN  = 4'b1111;
    localparam logic [6:0] IDLE_SEG = 7'b1111111;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  inv;
        logic        fv;
        logic [7:0]  err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   t_drive = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    seg7_scan_if #(.DIGITS(4)) bus ();

    seg7_scan_decoder #(.DIGITS(4), .STABLE_CYC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef SEG7_ERR_CNT_EN
    wire [7:0] err_obs = bus.err_cnt;
`else
    wire [7:0] err_obs = 8'h00;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one pattern for n sampled edges; optionally expect a visible update 5 edges later.
    task automatic step(input logic [3:0] an, input logic [6:0] seg, input int n,
                        input bit push, input logic [15:0] d, input logic [3:0] inv,
                        input logic fv, input logic [7:0] err);
        exp_t e;
        @(negedge clk);
        #1;
        bus.an_in  = an;
        bus.seg_in = seg;
        t_drive    = cyc;
        if (push) begin
            e.d = d; e.inv = inv; e.fv = fv; e.err = err; e.cyc = t_drive + 5;
            sb.push_back(e);
        end
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        step(IDLE_AN, IDLE_SEG, n, 1'b0, 16'h0, 4'h0, 1'b0, 8'h0);
    endtask

    // Monitor: any change of digits/invalid/err, or a frame pulse, is one DUT response.
    logic [27:0] prev;
    logic [27:0] cur;
    always @(negedge clk) begin
        exp_t e;
        cur = {bus.digits_out, bus.invalid_out, err_obs};
        if (!rst && ((cur !== prev) || bus.frame_valid)) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {3'b0, bus.frame_valid, cur}, {4'b0, prev});
            end else begin
                e = sb.pop_front();
                check("digits_out", 32'(bus.digits_out), 32'(e.d));
                check("invalid_out", 32'(bus.invalid_out), 32'(e.inv));
                check("frame_valid", 32'(bus.frame_valid), 32'(e.fv));
`ifdef SEG7_ERR_CNT_EN
                check("err_cnt", 32'(bus.err_cnt), 32'(e.err));
`endif
                check("update_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        prev = cur;
    end

    initial begin
        bus.an_in  = IDLE_AN;
        bus.seg_in = IDLE_SEG;

        // 1: reset with idle inputs
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_digits", 32'(bus.digits_out), 32'h0000FFFF);
        check("reset_invalid", 32'(bus.invalid_out), 32'h0);
        check("reset_frame_valid", 32'(bus.frame_valid), 32'h0);
`ifdef SEG7_ERR_CNT_EN
        check("reset_err_cnt", 32'(bus.err_cnt), 32'h0);
`endif
        #1 rst = 1'b0;
        idle(6);

        // 2: full frame, digits 0..3 show 1,2,3,4
        step(4'b1110, 7'b1111001, 8, 1'b1, 16'hFFF1, 4'h0, 1'b0, 8'd0);
        step(4'b1101, 7'b0100100, 8, 1'b1, 16'hFF21, 4'h0, 1'b0, 8'd0);
        step(4'b1011, 7'b0110000, 8, 1'b1, 16'hF321, 4'h0, 1'b0, 8'd0);
        step(4'b0111, 7'b0011001, 8, 1'b1, 16'h4321, 4'h0, 1'b1, 8'd0);
        idle(8);

        // 3: 3-cycle glitch is ignored
        step(4'b1110, 7'b0010000, 3, 1'b0, 16'h0, 4'h0, 1'b0, 8'd0);
        idle(8);

        // 4: illegal pattern on digit 1
        step(4'b1101, 7'b0111111, 6, 1'b1, 16'h43E1, 4'b0010, 1'b0, 8'd1);
        idle(8);

        // 5: two anodes low -> anode error only
`ifdef SEG7_ERR_CNT_EN
        step(4'b0011, 7'b1000000, 10, 1'b1, 16'h43E1, 4'b0010, 1'b0, 8'd2);
`else
        step(4'b0011, 7'b1000000, 10, 1'b0, 16'h0, 4'h0, 1'b0, 8'd0);
`endif
        idle(8);

        // 6: partial frame (mask already holds digit 1), reset, then resume
        step(4'b1110, 7'b0010010, 8, 1'b1, 16'h43E5, 4'b0010, 1'b0, 8'd2);
        step(4'b1101, 7'b0000010, 8, 1'b1, 16'h4365, 4'b0000, 1'b0, 8'd2);
        @(negedge clk);
        #1;
        rst        = 1'b1;
        bus.an_in  = IDLE_AN;
        bus.seg_in = IDLE_SEG;
        @(negedge clk);
        #1 rst = 1'b0;
        step(4'b1011, 7'b1111000, 8, 1'b1, 16'hF7FF, 4'h0, 1'b0, 8'd0);
        step(4'b0111, 7'b0000000, 8, 1'b1, 16'h87FF, 4'h0, 1'b0, 8'd0);
        // Mask holds {2,3}; the scan completes the frame at digit 1, then starts a new one.
        step(4'b1110, 7'b0010000, 8, 1'b1, 16'h87F9, 4'h0, 1'b0, 8'd0);
        step(4'b1101, 7'b1000000, 8, 1'b1, 16'h8709, 4'h0, 1'b1, 8'd0);
        step(4'b1011, 7'b1111001, 8, 1'b1, 16'h8109, 4'h0, 1'b0, 8'd0);
        step(4'b0111, 7'b0100100, 8, 1'b1, 16'h2109, 4'h0, 1'b0, 8'd0);
        idle(10);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
